// File: rtl/display_pkg.sv
// Shared types and constants for the TIME/DATE display scheduler.
// Mode encoding, view constants and a width helper.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_EDIT   = 2'd2
  } mode_t;

  localparam logic SEL_TIME = 1'b0;
  localparam logic SEL_DATE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating seconds counter with clear, increment enable and a
// terminal-count compare against a per-use limit.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // count ticks, clear on request, never wrap
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/display_scheduler.sv
// Selects the TIME or DATE view: timed auto-cycling, manual toggle
// with a hold timeout, and a freeze on the field being edited.
module display_scheduler
  import display_pkg::*;
#(
  parameter int   TIME_DWELL  = 10,
  parameter int   DATE_DWELL  = 3,
  parameter int   MANUAL_HOLD = 30,
  parameter logic RESET_SEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       sel_p,
  input  logic       auto_en,
  input  logic       edit_active,
  input  logic       edit_sel,
  output logic       display_sel,
  output logic [1:0] mode,
  output logic       switch_p
);

  localparam int W =
    $clog2(max3(TIME_DWELL, DATE_DWELL, MANUAL_HOLD) + 1);

  mode_t        r_mode;
  mode_t        w_mode_nx;
  logic         r_sel;
  logic         w_sel_nx;
  logic         r_switch;
  logic         w_clr;
  logic         w_inc;
  logic         w_done;
  logic [W-1:0] w_limit;

  dwell_timer #(.W(W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .i_limit (w_limit),
    .o_done  (w_done)
  );

  // terminal count depends on the current mode and visible view
  always_comb begin
    w_limit = W'(MANUAL_HOLD - 1);
    unique case (r_mode)
      MODE_AUTO:
        w_limit = (r_sel == SEL_DATE) ? W'(DATE_DWELL - 1)
                                      : W'(TIME_DWELL - 1);
      MODE_MANUAL: w_limit = W'(MANUAL_HOLD - 1);
      default:     w_limit = '0;
    endcase
  end

  // next mode, next view and timer control, in event priority order
  always_comb begin
    w_mode_nx = r_mode;
    w_sel_nx  = r_sel;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    if (edit_active) begin
      w_mode_nx = MODE_EDIT;
      w_sel_nx  = edit_sel;
      w_clr     = 1'b1;
    end else if (r_mode == MODE_EDIT) begin
      w_mode_nx = MODE_MANUAL;
      w_clr     = 1'b1;
    end else if (sel_p) begin
      w_mode_nx = MODE_MANUAL;
      w_sel_nx  = ~r_sel;
      w_clr     = 1'b1;
    end else if (r_mode == MODE_AUTO) begin
      if (auto_en && tick_1hz) begin
        if (w_done) begin
          w_sel_nx = ~r_sel;
          w_clr    = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
    end else begin
      if (!auto_en) begin
        w_clr = 1'b1;
      end else if (tick_1hz) begin
        if (w_done) begin
          w_mode_nx = MODE_AUTO;
          w_sel_nx  = SEL_TIME;
          w_clr     = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
    end
  end

  // state, view and change-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_AUTO;
      r_sel    <= RESET_SEL;
      r_switch <= 1'b0;
    end else begin
      r_mode   <= w_mode_nx;
      r_sel    <= w_sel_nx;
      r_switch <= (w_sel_nx != r_sel);
    end
  end

  assign display_sel = r_sel;
  assign mode        = r_mode;
  assign switch_p    = r_switch;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios
// plus random traffic against a behavioural view/mode model.
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       sel_p = 1'b0;
  logic       auto_en = 1'b1;
  logic       edit_active = 1'b0;
  logic       edit_sel = 1'b0;
  logic       display_sel;
  logic [1:0] mode;
  logic       switch_p;

  int n_chk = 0;
  int n_err = 0;

  int m_view = 0;
  int m_mode = 0;
  int m_secs = 0;
  int m_sw = 0;

  display_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .sel_p       (sel_p),
    .auto_en     (auto_en),
    .edit_active (edit_active),
    .edit_sel    (edit_sel),
    .display_sel (display_sel),
    .mode        (mode),
    .switch_p    (switch_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model: m_secs is seconds elapsed in the current
  // dwell or hold period; mode 0 auto, 1 manual, 2 edit
  task automatic model();
    int prev;
    int dwell;
    prev = m_view;
    if (rst) begin
      m_view = 0; m_mode = 0; m_secs = 0;
    end else if (edit_active) begin
      m_mode = 2; m_secs = 0; m_view = int'(edit_sel);
    end else if (m_mode == 2) begin
      m_mode = 1; m_secs = 0;
    end else if (sel_p) begin
      m_view = 1 - m_view; m_mode = 1; m_secs = 0;
    end else if (m_mode == 0) begin
      if (auto_en && tick_1hz) begin
        dwell = (m_view == 1) ? 3 : 10;
        m_secs++;
        if (m_secs == dwell) begin
          m_view = 1 - m_view; m_secs = 0;
        end
      end
    end else begin
      if (!auto_en) m_secs = 0;
      else if (tick_1hz) begin
        m_secs++;
        if (m_secs == 30) begin
          m_mode = 0; m_view = 0; m_secs = 0;
        end
      end
    end
    m_sw = (!rst && m_view != prev) ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("sel", int'(display_sel), m_view);
    chk("mode", int'(mode), m_mode);
    chk("sw", int'(switch_p), m_sw);
    rst = 1'b0;
    tick_1hz = 1'b0;
    sel_p = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cyc();
      cyc();
    end
  endtask

  int exp_v;

  initial begin
    // reset state
    rst = 1'b1;
    cyc();
    chk("rst_sel", int'(display_sel), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_sw", int'(switch_p), 0);
    cyc();

    // auto cycling: DATE during ticks 10..12 and 23..25
    auto_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick_1hz = 1'b1;
      cyc();
      exp_v = ((k >= 10 && k < 13) || (k >= 23 && k < 26)) ? 1 : 0;
      chk("t1_view", int'(display_sel), exp_v);
      cyc();
    end

    // manual toggle then hold timeout
    do_reset();
    ticks(5);
    sel_p = 1'b1;
    cyc();
    chk("t2_sel", int'(display_sel), 1);
    chk("t2_mode", int'(mode), 1);
    chk("t2_sw", int'(switch_p), 1);
    ticks(29);
    chk("t2_hold", int'(mode), 1);
    tick_1hz = 1'b1;
    cyc();
    chk("t2_back", int'(mode), 0);
    chk("t2_time", int'(display_sel), 0);

    // tick and toggle in the same cycle at cnt 9
    do_reset();
    ticks(9);
    sel_p = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    chk("t3_sel", int'(display_sel), 1);
    chk("t3_mode", int'(mode), 1);
    ticks(29);
    chk("t3_cnt0", int'(mode), 1);
    ticks(1);
    chk("t3_auto", int'(mode), 0);

    // edit freeze
    edit_sel = 1'b1;
    edit_active = 1'b1;
    cyc();
    chk("t4_edit", int'(mode), 2);
    chk("t4_esel", int'(display_sel), 1);
    for (int i = 0; i < 3; i++) begin
      sel_p = 1'b1;
      cyc();
    end
    chk("t4_frz", int'(display_sel), 1);
    edit_sel = 1'b0;
    cyc();
    chk("t4_trk", int'(display_sel), 0);
    edit_active = 1'b0;
    cyc();
    chk("t4_man", int'(mode), 1);
    chk("t4_keep", int'(display_sel), 0);

    // auto disabled
    do_reset();
    auto_en = 1'b0;
    ticks(100);
    chk("t5_const", int'(display_sel), 0);
    sel_p = 1'b1;
    cyc();
    ticks(100);
    chk("t5_nohold", int'(mode), 1);
    auto_en = 1'b1;
    ticks(29);
    chk("t5_29", int'(mode), 1);
    ticks(1);
    chk("t5_30", int'(mode), 0);

    // reset mid-hold
    do_reset();
    sel_p = 1'b1;
    cyc();
    ticks(20);
    chk("t6_pre", int'(display_sel), 1);
    rst = 1'b1;
    cyc();
    chk("t6_sel", int'(display_sel), 0);
    chk("t6_mode", int'(mode), 0);
    chk("t6_sw", int'(switch_p), 0);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      tick_1hz = ($urandom_range(0, 2) == 0);
      sel_p = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 149) == 0) edit_active = ~edit_active;
      if ($urandom_range(0, 9) == 0) edit_sel = $urandom_range(0, 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequences the TIME/DATE view for the 7-segment display path: automatically alternates the two views on programmable dwell times and accepts a manual toggle pulse from KEY0. After a manual toggle it holds the chosen view for a hold period, then resumes auto-cycling. While a set/edit operation is active, it freezes the view on the field being edited. It replaces a plain toggle flop as the sole driver of `display_sel` into the display mux.

## Interface

Parameters:
- `TIME_DWELL`, default 10: seconds TIME is shown per auto cycle (≥1).
- `DATE_DWELL`, default 3: seconds DATE is shown per auto cycle (≥1).
- `MANUAL_HOLD`, default 30: seconds of inactivity before MANUAL returns to AUTO (≥1).
- `RESET_SEL`, default 1'b0: `display_sel` value after reset (0 = TIME, 1 = DATE).

Ports:
- `clk`, input, 1: system clock. One clock only; all logic is on its rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `tick_1hz`, input, 1: one-cycle pulse once per second.
- `sel_p`, input, 1: one-pulse manual toggle (debounced KEY0).
- `auto_en`, input, 1: level signal; 1 enables auto-cycling and the hold timeout.
- `edit_active`, input, 1: level signal; a set/edit operation is in progress.
- `edit_sel`, input, 1: the view being edited (0 = TIME, 1 = DATE). Sampled only while `edit_active` is 1.
- `display_sel`, output, 1: the selected view (0 = TIME, 1 = DATE). Registered.
- `mode`, output, 2: current state (AUTO = 0, MANUAL = 1, EDIT = 2). Registered.
- `switch_p`, output, 1: one-cycle pulse in the cycle where `display_sel` shows a new value. Registered.

## Operation

States are AUTO, MANUAL and EDIT. A seconds counter `cnt` is internal; its width is `$clog2(max(TIME_DWELL, DATE_DWELL, MANUAL_HOLD)+1)`. It saturates and never wraps.

Event priority each cycle is: `rst` > `edit_active` > `sel_p` > `tick_1hz`.

- **Any state, `edit_active`=1:** go to EDIT and set `cnt`=0. Set `display_sel` to `edit_sel`.
- **EDIT, `edit_active`=1:** ignore `sel_p` and ticks. Track `edit_sel` every cycle.
- **EDIT, `edit_active`=0:** go to MANUAL with `cnt`=0. Keep `display_sel` unchanged.
- **AUTO or MANUAL, `sel_p`=1:** toggle `display_sel`, go to MANUAL, set `cnt`=0. A tick in the same cycle is discarded.
- **AUTO, tick, `auto_en`=1:** let DWELL = `TIME_DWELL` if `display_sel`=0, otherwise `DATE_DWELL`.
  - If `cnt` = DWELL−1: toggle `display_sel` and set `cnt`=0.
  - Otherwise: increment `cnt`.
- **AUTO, `auto_en`=0:** hold `cnt` and `display_sel`.
- **MANUAL, tick, `auto_en`=1:**
  - If `cnt` = `MANUAL_HOLD`−1: go to AUTO, force `display_sel`=0 (TIME), set `cnt`=0.
  - Otherwise: increment `cnt`.
- **MANUAL, `auto_en`=0:** set `cnt`=0 and remain in MANUAL indefinitely.
- **`switch_p`:** asserted for exactly the one cycle in which registered `display_sel` first differs from its previous value. A forced TIME that equals the current view produces no pulse.

## Timing

- **Reset values:** `display_sel`=`RESET_SEL`, `mode`=AUTO, `switch_p`=0, `cnt`=0. Reset mid-dwell or mid-edit discards all progress.
- **`sel_p` latency:** `sel_p` high at edge N gives a new `display_sel` and `switch_p`=1 in the cycle after edge N (latency 1).
- **Auto dwell:** TIME is visible for exactly `TIME_DWELL` ticks and DATE for exactly `DATE_DWELL` ticks.
- **First dwell after reset:** starts counting from the first tick.
- **`edit_active` latency:** rise gives EDIT state and `edit_sel` on `display_sel` one cycle later. Fall gives MANUAL one cycle later.
- **Back-to-back `sel_p`** on consecutive cycles: each one toggles.
- **`auto_en` rising while in MANUAL:** the hold timer starts from `cnt`=0.

## Structure

- **Shared package `display_pkg`:**
  - `mode_t` encoding (AUTO/MANUAL/EDIT = 0/1/2).
  - Constants `SEL_TIME`=1'b0 and `SEL_DATE`=1'b1.
- **Sub-module `dwell_timer`:** a tick-driven counter with synchronous clear, enable, a `limit` input and a `done` compare output. It is instantiated once; the FSM drives `limit` from the current state and view.

## Test plan

1. **Auto cycling.** Reset with defaults, `auto_en`=1, 30 ticks → `display_sel` goes 0→1 after tick 10, 1→0 after tick 13, 0→1 after tick 23. Each change has `switch_p`=1 for one cycle.
2. **Manual toggle and hold timeout.** After tick 5, `sel_p` → `display_sel`=1 next cycle and `mode`=MANUAL. 29 more ticks → still MANUAL. Tick 30 → AUTO with `display_sel`=0.
3. **Tick/toggle collision.** `sel_p` and `tick_1hz` in the same cycle while in AUTO with `cnt`=9 on TIME → a single toggle to DATE, `mode`=MANUAL, `cnt`=0. No double toggle.
4. **Edit freeze.** Set `edit_active`=1 with `edit_sel`=1, then pulse `sel_p` 3 times → `display_sel` stays 1 and `mode`=EDIT. Change `edit_sel` to 0 → `display_sel`=0 next cycle. Drop `edit_active` → MANUAL.
5. **Auto disabled.** `auto_en`=0 for 100 ticks → `display_sel` is constant. From MANUAL, there is no timeout. Set `auto_en` to 1 → return to AUTO after exactly 30 ticks.
6. **Reset mid-operation.** Assert `rst` in MANUAL with `cnt`=20 and `display_sel`=1 → next cycle `display_sel`=0 (with `RESET_SEL`=0), `mode`=AUTO, `switch_p`=0.
